ps2_keyboard_commander: RTL and testbench
=========================================

# ps2_keyboard_commander

Host-to-keyboard command sequencer on the PS/2 transmit side. It issues LED-set (0xED) and reset (0xFF) command sequences through the PS2_Controller send interface (commandToSend/sendCommand). It then consumes the keyboard's response bytes (0xFA ack, 0xFE resend, 0xAA/0xFC self-test result). It sits beside the scancode decoder in the top level and flags response bytes so the decoder does not treat them as keystrokes.

## Interface
Parameters:
- ACK_TIMEOUT_CYCLES, 1000000 — cycles (20 ms at 50 MHz) to wait for an ack or resend after a byte is sent.
- BAT_TIMEOUT_CYCLES, 50000000 — cycles (1 s) to wait for the self-test result after the reset is acked.
- MAX_RETRIES, 3 — resend attempts per byte before the sequence is aborted.

Ports:
- CLOCK_50 in 1 — system clock; the only clock.
- resetn in 1 — synchronous, active-high reset (one clock; reset is synchronous and active-high).
- requestLeds in 1 — one-cycle pulse; starts the LED-set sequence.
- ledMask in 3 — {caps, num, scroll}; latched when requestLeds is accepted.
- requestReset in 1 — one-cycle pulse; starts the keyboard reset sequence.
- commandToSend out 8 — byte presented to PS2_Controller.
- sendCommand out 1 — level request to PS2_Controller.
- commandWasSent in 1 — one-cycle pulse from the controller when a byte has been transmitted.
- errorCommunicationTimedOut in 1 — one-cycle pulse from the controller on a transmit failure.
- recievedData in 8 — received byte.
- recievedNewData in 1 — one-cycle strobe; recievedData is valid in the same cycle.
- busy out 1 — high from the cycle after acceptance until done or error.
- responseFilter out 1 — high while a sequence is active (equal to busy); tells the decoder to drop 0xFA/0xFE/0xAA/0xFC.
- done out 1 — one-cycle pulse on successful completion.
- error out 1 — one-cycle pulse on abort.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT, FINISH, FAIL.
- IDLE: requestReset has priority over requestLeds when both are high.
  - Reset request: byte list is {0xFF}, then a self-test result is expected.
  - LED request: byte list is {0xED, {5'b0, ledMask}}.
  - Requests arriving outside IDLE are ignored and not queued.
- SEND: drive commandToSend with the current byte and assert sendCommand; go to WAIT_SENT.
- WAIT_SENT: hold sendCommand and commandToSend stable.
  - commandWasSent: deassert sendCommand, clear the timer, go to WAIT_ACK.
  - errorCommunicationTimedOut: go to FAIL. Retries do not apply.
  - Received bytes are ignored in this state.
- WAIT_ACK: the timer counts every cycle. On recievedNewData:
  - 0xFA: advance to the next byte (SEND). After the last byte, go to WAIT_BAT for a reset sequence, else FINISH.
  - 0xFE: retry.
  - Any other byte: ignored; the timer keeps running.
- Timer reaching ACK_TIMEOUT_CYCLES-1 counts as a retry.
- Retry: if retryCount < MAX_RETRIES, increment it and resend the same byte (SEND); otherwise go to FAIL. retryCount clears per byte.
- WAIT_BAT: 0xAA → FINISH. 0xFC, or timer reaching BAT_TIMEOUT_CYCLES-1 → FAIL. Other bytes are ignored.
- FINISH pulses done; FAIL pulses error. Both return to IDLE the next cycle.
- Reset mid-sequence: the next edge forces IDLE, drops sendCommand, and discards the latched mask and retry count.

## Timing
- Reset values: commandToSend=0x00, sendCommand=0, busy=0, responseFilter=0, done=0, error=0.
- Request accepted in cycle N: busy and sendCommand are high in cycle N+1, with commandToSend = first byte.
- commandWasSent in cycle M: sendCommand is low in cycle M+1.
- Ack in cycle K: sendCommand for the next byte is high in K+2 (via SEND).
- done/error are high for exactly one cycle; busy falls in the same cycle done/error is high.
- A new request is accepted in the cycle after done/error.
- Timer width is $clog2(max(ACK_TIMEOUT_CYCLES, BAT_TIMEOUT_CYCLES)). It saturates and never wraps.

## Structure
- DefineMacros.vh gains:
  - `PS2CMD_SETLEDS (8'hED), `PS2CMD_RESET (8'hFF)
  - `PS2RSP_ACK (8'hFA), `PS2RSP_RESEND (8'hFE), `PS2RSP_BATOK (8'hAA), `PS2RSP_BATFAIL (8'hFC)
  - the state encodings
- Sub-module: ps2_response_timer — clear/enable counter with a terminal-count compare input. It is instantiated once and shared by WAIT_ACK and WAIT_BAT.

## Test plan
- LED set: requestLeds with ledMask=3'b101; model acks each byte. Expect bytes 0xED then 0x05 on commandToSend, done pulses once, and busy is high throughout.
- Reset: requestReset; model acks 0xFF, then sends 0xAA. Expect done. Repeat with 0xFC in place of 0xAA: expect error, no done.
- Resend: model answers 0xFE twice, then 0xFA. Expect 0xED sent three times, then success. With 0xFE four times: expect error after the fourth response.
- Ack timeout (ACK_TIMEOUT_CYCLES=100): model never replies. Expect resends at roughly 100-cycle spacing, then error after 3 retries.
- Interleaved traffic: a scancode 0x1C arrives in WAIT_ACK and is ignored, then 0xFA advances the sequence. requestLeds asserted while busy is ignored.
- Priority and reset: requestReset and requestLeds in the same cycle → 0xFF is sent. Assert resetn during WAIT_ACK → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ps2_keyboard_commander_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_keyboard_commander_pkg                                                 |
// | PS/2 host command/response byte codes, sequencer states, sizing helpers.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ps2_keyboard_commander_pkg;

  localparam logic [7:0] PS2CMD_SETLEDS = 8'hED;
  localparam logic [7:0] PS2CMD_RESET   = 8'hFF;

  localparam logic [7:0] PS2RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2RSP_RESEND  = 8'hFE;
  localparam logic [7:0] PS2RSP_BATOK   = 8'hAA;
  localparam logic [7:0] PS2RSP_BATFAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_BAT  = 3'd4,
    ST_FINISH    = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  // Shared timer must reach the larger of the two terminal counts.
  function automatic int timer_width(input int ack_cycles, input int bat_cycles);
    int m;
    int w;
    m = (ack_cycles > bat_cycles) ? ack_cycles : bat_cycles;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int retry_width(input int max_retries);
    int w;
    w = $clog2(max_retries + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_response_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_response_timer                                                         |
// | Clear/enable saturating counter with a terminal-count compare input.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_response_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             hit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == terminal);

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_commander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_keyboard_commander                                                     |
// | Issues LED-set / reset command sequences to a PS/2 keyboard and consumes   |
// | its ack/resend/self-test responses.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_keyboard_commander
  import ps2_keyboard_commander_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYCLES = 1000000,
  parameter int BAT_TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       requestLeds,
  input  logic [2:0] ledMask,
  input  logic       requestReset,
  output logic [7:0] commandToSend,
  output logic       sendCommand,
  input  logic       commandWasSent,
  input  logic       errorCommunicationTimedOut,
  input  logic [7:0] recievedData,
  input  logic       recievedNewData,
  output logic       busy,
  output logic       responseFilter,
  output logic       done,
  output logic       error
);

  localparam int TW = timer_width(ACK_TIMEOUT_CYCLES, BAT_TIMEOUT_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);

  localparam logic [TW-1:0] ACK_TC      = TW'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BAT_TC      = TW'(BAT_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          send_q, send_d;
  logic          byte_idx_q, byte_idx_d;
  logic          is_reset_q, is_reset_d;
  logic [2:0]    mask_q, mask_d;
  logic [RW-1:0] retry_q, retry_d;

  logic          timer_clear;
  logic          timer_enable;
  logic          timer_hit;
  logic [TW-1:0] timer_terminal;
  logic          retry_req;
  logic          last_byte;

  assign timer_terminal = (state_q == ST_WAIT_BAT) ? BAT_TC : ACK_TC;
  // A reset sequence has a single byte; an LED sequence ends on its second.
  assign last_byte      = is_reset_q | byte_idx_q;

  ps2_response_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (CLOCK_50),
    .rst      (resetn),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timer_terminal),
    .hit      (timer_hit)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    send_d       = send_q;
    byte_idx_d   = byte_idx_q;
    is_reset_d   = is_reset_q;
    mask_d       = mask_q;
    retry_d      = retry_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    retry_req    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        send_d = 1'b0;
        if (requestReset) begin
          is_reset_d = 1'b1;
          byte_idx_d = 1'b0;
          retry_d    = '0;
          cmd_d      = PS2CMD_RESET;
          send_d     = 1'b1;
          state_d    = ST_SEND;
        end else if (requestLeds) begin
          is_reset_d = 1'b0;
          mask_d     = ledMask;
          byte_idx_d = 1'b0;
          retry_d    = '0;
          cmd_d      = PS2CMD_SETLEDS;
          send_d     = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        send_d  = 1'b1;
        state_d = ST_WAIT_SENT;
      end

      ST_WAIT_SENT: begin
        if (errorCommunicationTimedOut) begin
          send_d  = 1'b0;
          state_d = ST_FAIL;
        end else if (commandWasSent) begin
          send_d      = 1'b0;
          timer_clear = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        timer_enable = 1'b1;
        // A real response wins over a timeout landing in the same cycle.
        if (recievedNewData && (recievedData == PS2RSP_ACK)) begin
          if (last_byte) begin
            if (is_reset_q) begin
              timer_clear = 1'b1;
              state_d     = ST_WAIT_BAT;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            byte_idx_d = 1'b1;
            retry_d    = '0;
            cmd_d      = {5'b00000, mask_q};
            state_d    = ST_SEND;
          end
        end else if (recievedNewData && (recievedData == PS2RSP_RESEND)) begin
          retry_req = 1'b1;
        end else if (timer_hit) begin
          retry_req = 1'b1;
        end
      end

      ST_WAIT_BAT: begin
        timer_enable = 1'b1;
        if (recievedNewData && (recievedData == PS2RSP_BATOK)) begin
          state_d = ST_FINISH;
        end else if ((recievedNewData && (recievedData == PS2RSP_BATFAIL)) || timer_hit) begin
          state_d = ST_FAIL;
        end
      end

      ST_FINISH: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_FAIL: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (retry_req) begin
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 1'b1;
        state_d = ST_SEND;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      send_q     <= 1'b0;
      byte_idx_q <= 1'b0;
      is_reset_q <= 1'b0;
      mask_q     <= 3'b000;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      send_q     <= send_d;
      byte_idx_q <= byte_idx_d;
      is_reset_q <= is_reset_d;
      mask_q     <= mask_d;
      retry_q    <= retry_d;
    end
  end

  assign commandToSend  = cmd_q;
  assign sendCommand    = send_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_FINISH) && (state_q != ST_FAIL);
  assign responseFilter = busy;
  assign done           = (state_q == ST_FINISH);
  assign error          = (state_q == ST_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_commander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_keyboard_commander                                                  |
// | Scripted keyboard/controller emulator with a transaction-level model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_keyboard_commander;

  localparam int ACK  = 100;
  localparam int BAT  = 300;
  localparam int MAXR = 3;

  logic       clk;
  logic       resetn;
  logic       requestLeds;
  logic [2:0] ledMask;
  logic       requestReset;
  logic [7:0] commandToSend;
  logic       sendCommand;
  logic       commandWasSent;
  logic       errorCommunicationTimedOut;
  logic [7:0] recievedData;
  logic       recievedNewData;
  logic       busy;
  logic       responseFilter;
  logic       done;
  logic       error;

  ps2_keyboard_commander #(
    .ACK_TIMEOUT_CYCLES (ACK),
    .BAT_TIMEOUT_CYCLES (BAT),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .CLOCK_50                   (clk),
    .resetn                     (resetn),
    .requestLeds                (requestLeds),
    .ledMask                    (ledMask),
    .requestReset               (requestReset),
    .commandToSend              (commandToSend),
    .sendCommand                (sendCommand),
    .commandWasSent             (commandWasSent),
    .errorCommunicationTimedOut (errorCommunicationTimedOut),
    .recievedData               (recievedData),
    .recievedNewData            (recievedNewData),
    .busy                       (busy),
    .responseFilter             (responseFilter),
    .done                       (done),
    .error                      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       chk_en   = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_send = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_err  = 1'b0;
  logic [7:0] exp_byte = 8'h00;

  logic [7:0] got_q[$];
  logic [7:0] model_q[$];
  bit         model_ok;
  logic       send_prev = 1'b0;
  int         n_done = 0;
  int         n_err  = 0;
  int         last_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the scripted expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outputs",
            {19'd0, busy, responseFilter, done, error, sendCommand, (sendCommand ? commandToSend : 8'h00)},
            {19'd0, exp_busy, exp_busy, exp_done, exp_err, exp_send, (exp_send ? exp_byte : 8'h00)});
    end
  end

  always @(negedge clk) begin
    send_prev <= sendCommand;
    if (chk_en && (sendCommand === 1'b1) && (send_prev === 1'b0)) got_q.push_back(commandToSend);
    if (chk_en && (done === 1'b1)) n_done <= n_done + 1;
    if (chk_en && (error === 1'b1)) n_err <= n_err + 1;
  end

  // Every call ends 1 time unit after a rising edge: outputs show the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    requestLeds                = 1'b0;
    requestReset               = 1'b0;
    commandWasSent             = 1'b0;
    errorCommunicationTimedOut = 1'b0;
    recievedNewData            = 1'b0;
    resetn                     = 1'b0;
    exp_done                   = 1'b0;
    exp_err                    = 1'b0;
  endtask

  // ctx: 0 while sending, 1 awaiting ack, 2 awaiting self-test result.
  task automatic noise(input int ctx);
    logic [7:0] j;
    if ($urandom_range(0, 7) == 0) begin
      j = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'($urandom);
      if (ctx == 1 && (j == 8'hFA || j == 8'hFE)) j = 8'h1C;
      if (ctx == 2 && (j == 8'hAA || j == 8'hFC)) j = 8'h1C;
      recievedData    = j;
      recievedNewData = 1'b1;
    end
    if ($urandom_range(0, 15) == 0) begin
      ledMask     = 3'($urandom);
      requestLeds = 1'b1;
    end
    if ($urandom_range(0, 31) == 0) requestReset = 1'b1;
  endtask

  task automatic finish_seq(input bit ok);
    exp_busy = 1'b0;
    exp_send = 1'b0;
    if (ok) exp_done = 1'b1;
    else    exp_err  = 1'b1;
    step();
  endtask

  task automatic bat_phase(input int kind);
    if (kind == 2) begin
      repeat (BAT) begin noise(2); step(); end
      finish_seq(1'b0);
    end else begin
      repeat ($urandom_range(0, 30)) begin noise(2); step(); end
      recievedData    = (kind == 0) ? 8'hAA : 8'hFC;
      recievedNewData = 1'b1;
      step();
      finish_seq(kind == 0);
    end
  endtask

  // Expected transmitted stream and outcome from the command rules alone.
  task automatic predict(input bit is_rst, input logic [2:0] mask, input int nb0, input int nb1,
                         input int bat_kind, input bit txfail);
    logic [7:0] bl[2];
    int nb[2];
    int nbytes;
    bl[0] = is_rst ? 8'hFF : 8'hED;
    bl[1] = {5'b00000, mask};
    nb[0] = nb0;
    nb[1] = nb1;
    nbytes = is_rst ? 1 : 2;
    model_q.delete();
    model_ok = 1'b1;
    if (txfail) begin
      model_q.push_back(bl[0]);
      model_ok = 1'b0;
    end else begin
      for (int i = 0; i < nbytes && model_ok; i++) begin
        for (int t = 0; t <= ((nb[i] < MAXR) ? nb[i] : MAXR); t++) model_q.push_back(bl[i]);
        if (nb[i] > MAXR) model_ok = 1'b0;
      end
      if (model_ok && is_rst) model_ok = (bat_kind == 0);
    end
  endtask

  // mode: 0 random bad-response kind, 1 always 0xFE, 2 always silence.
  task automatic run_seq(input bit is_rst, input logic [2:0] mask, input bit both, input int nb0,
                         input int nb1, input int bat_kind, input bit txfail, input int mode);
    logic [7:0] bytes[2];
    int  nb[2];
    int  nbytes, i, a, ndone0, nerr0;
    bit  finished, next_byte, bad;
    bytes[0]  = is_rst ? 8'hFF : 8'hED;
    bytes[1]  = {5'b00000, mask};
    nb[0]     = nb0;
    nb[1]     = nb1;
    nbytes    = is_rst ? 1 : 2;
    last_base = got_q.size();
    ndone0    = n_done;
    nerr0     = n_err;
    predict(is_rst, mask, nb0, nb1, bat_kind, txfail);

    ledMask = mask;
    if (is_rst || both) requestReset = 1'b1;
    if (!is_rst || both) requestLeds = 1'b1;
    step();
    exp_busy = 1'b1;
    exp_send = 1'b1;
    exp_byte = bytes[0];

    i = 0;
    finished = 1'b0;
    while (!finished) begin
      a = 0;
      next_byte = 1'b0;
      while (!finished && !next_byte) begin
        repeat ($urandom_range(1, 4)) begin noise(0); step(); end
        if (txfail) begin
          errorCommunicationTimedOut = 1'b1;
          step();
          finish_seq(1'b0);
          finished = 1'b1;
        end else begin
          commandWasSent = 1'b1;
          step();
          exp_send = 1'b0;
          bad = (a < nb[i]);
          if (bad && (mode == 2 || (mode == 0 && $urandom_range(0, 3) == 0))) begin
            repeat (ACK) begin noise(1); step(); end
          end else begin
            repeat ($urandom_range(0, 30)) begin noise(1); step(); end
            recievedData    = bad ? 8'hFE : 8'hFA;
            recievedNewData = 1'b1;
            step();
          end
          if (bad) begin
            if (a >= MAXR) begin
              finish_seq(1'b0);
              finished = 1'b1;
            end else begin
              a++;
              step();
              exp_send = 1'b1;
            end
          end else if (i == nbytes - 1) begin
            if (is_rst) bat_phase(bat_kind);
            else        finish_seq(1'b1);
            finished = 1'b1;
          end else begin
            i++;
            next_byte = 1'b1;
            step();
            exp_send = 1'b1;
            exp_byte = bytes[i];
          end
        end
      end
    end

    check("tx_count", got_q.size() - last_base, model_q.size());
    for (int k = 0; k < model_q.size() && (last_base + k) < got_q.size(); k++)
      check("tx_byte", got_q[last_base + k], model_q[k]);
    check("done_count", n_done - ndone0, {31'd0, model_ok});
    check("error_count", n_err - nerr0, {31'd0, !model_ok});
  endtask

  function automatic int pick_bad();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 7) return 1;
    return r - 6;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=time limit reached required=run completes");
    $fatal(1);
  end

  initial begin
    bit         r_is_rst, r_both, r_txf;
    logic [2:0] r_mask;
    int         r_nb0, r_nb1, r_bat, rb;

    requestLeds = 1'b0; requestReset = 1'b0; ledMask = 3'b000;
    commandWasSent = 1'b0; errorCommunicationTimedOut = 1'b0;
    recievedData = 8'h00; recievedNewData = 1'b0;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    chk_en = 1'b1;
    check("reset_cmd", {24'd0, commandToSend}, 32'h0);
    check("reset_flags", {27'd0, sendCommand, busy, responseFilter, done, error}, 32'h0);
    step();

    // LED set with mask 101: bytes ED then 05.
    run_seq(1'b0, 3'b101, 1'b0, 0, 0, 0, 1'b0, 0);
    check("led_byte0", {24'd0, got_q[last_base]}, 32'hED);
    check("led_byte1", {24'd0, got_q[last_base + 1]}, 32'h05);

    run_seq(1'b1, 3'b000, 1'b0, 0, 0, 0, 1'b0, 0);   // reset, self-test passes
    run_seq(1'b1, 3'b000, 1'b0, 0, 0, 1, 1'b0, 0);   // reset, self-test fails
    run_seq(1'b1, 3'b000, 1'b0, 0, 0, 2, 1'b0, 0);   // reset, self-test silent

    run_seq(1'b0, 3'b011, 1'b0, 2, 0, 0, 1'b0, 1);   // two resends then ack
    check("resend_total", got_q.size() - last_base, 32'd4);
    run_seq(1'b0, 3'b011, 1'b0, 4, 0, 0, 1'b0, 1);   // four resends: abort
    run_seq(1'b0, 3'b110, 1'b0, 4, 0, 0, 1'b0, 2);   // never answered: abort
    run_seq(1'b0, 3'b110, 1'b0, 0, 3, 0, 1'b0, 2);   // three timeouts on byte 2

    run_seq(1'b1, 3'b010, 1'b1, 0, 0, 0, 1'b0, 0);   // both requests: reset wins
    check("prio_byte0", {24'd0, got_q[last_base]}, 32'hFF);

    run_seq(1'b0, 3'b111, 1'b0, 0, 0, 0, 1'b1, 0);   // controller transmit failure

    // Reset asserted while awaiting an ack, after one resend.
    ledMask = 3'b111; requestLeds = 1'b1;
    step(); exp_busy = 1'b1; exp_send = 1'b1; exp_byte = 8'hED;
    step(); commandWasSent = 1'b1;
    step(); exp_send = 1'b0;
    recievedData = 8'hFE; recievedNewData = 1'b1;
    step();
    step(); exp_send = 1'b1;
    step(); commandWasSent = 1'b1;
    step(); exp_send = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step(); exp_busy = 1'b0; exp_send = 1'b0;
    check("midreset_cmd", {24'd0, commandToSend}, 32'h0);
    step();
    run_seq(1'b0, 3'b001, 1'b0, 3, 0, 0, 1'b0, 1);
    check("after_reset_mask", {24'd0, got_q[last_base + 4]}, 32'h01);

    for (int s = 0; s < 40; s++) begin
      r_is_rst = ($urandom_range(0, 2) == 0);
      r_both   = r_is_rst && ($urandom_range(0, 3) == 0);
      r_mask   = 3'($urandom);
      r_nb0    = pick_bad();
      r_nb1    = pick_bad();
      rb       = $urandom_range(0, 5);
      r_bat    = (rb < 4) ? 0 : rb - 3;
      r_txf    = ($urandom_range(0, 19) == 0);
      run_seq(r_is_rst, r_mask, r_both, r_nb0, r_nb1, r_bat, r_txf, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
